// File: rtl/therm_pkg.sv
// therm_pkg: shared thermometer-datapath sizes and width helper.
// Ports: none (package). Used by the bubble-correction, encoder and decimation stages.
package therm_pkg;
   localparam int THERM_N      = 255;
   localparam int THERM_CODE_W = 8;
   function automatic int therm_code_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/onehot_or_encoder.sv
// onehot_or_encoder: combinational one-hot to binary OR-encoder, code = index+1 or 0 for no bit set.
// Ports: onehot [N-1:0] in, code [CODE_W-1:0] out.
module onehot_or_encoder
   import therm_pkg::*;
#(
   parameter int N      = THERM_N,
   parameter int CODE_W = therm_code_w(N)
) (
   input  logic [N-1:0]      onehot,
   output logic [CODE_W-1:0] code
);
   // Each set bit contributes its index+1; with a true one-hot this is an exact encode.
   always_comb begin
      code = '0;
      for (int i = 0; i < N; i++) code = code | ({CODE_W{onehot[i]}} & CODE_W'(i + 1));
   end
endmodule

// File: rtl/therm_encoder.sv
// therm_encoder: 3-stage thermometer-to-binary encoder that repeats the last good code on a bubble.
// Ports: clk, rst (sync, active-high), in_valid, therm_in [N-1:0] in;
//        out_valid, code_out [CODE_W-1:0], err_out out; err_cnt [15:0] out with THERM_ENC_ERR_CNT_EN.
module therm_encoder
   import therm_pkg::*;
#(
   parameter int N      = THERM_N,
   parameter int CODE_W = therm_code_w(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [N-1:0]      therm_in,
   output logic              out_valid,
   output logic [CODE_W-1:0] code_out,
   output logic              err_out
`ifdef THERM_ENC_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt
`endif
);
   logic [N-1:0]      th, t;
   logic              v1, v2, nonmono, nm2;
   logic [CODE_W-1:0] raw, raw2, last_good;
   // Transition sits where a 1 is followed by a 0 above it; the top bit has nothing above.
   assign t       = th & ~{1'b0, th[N-1:1]};
   assign nonmono = |(th[N-1:1] & ~th[N-2:0]);
   onehot_or_encoder #(.N(N), .CODE_W(CODE_W)) enc (.onehot(t), .code(raw));
   always_ff @(posedge clk) begin
      if (rst) begin
         th        <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         nm2       <= 1'b0;
         raw2      <= '0;
         out_valid <= 1'b0;
         code_out  <= '0;
         err_out   <= 1'b0;
         last_good <= '0;
      end else begin
         v1        <= in_valid;
         th        <= in_valid ? therm_in : th;
         v2        <= v1;
         nm2       <= nonmono;
         raw2      <= raw;
         out_valid <= v2;
         if (v2) begin
            code_out  <= nm2 ? last_good : raw2;
            err_out   <= nm2;
            last_good <= nm2 ? last_good : raw2;
         end
      end
   end
`ifdef THERM_ENC_ERR_CNT_EN
   always_ff @(posedge clk)
      if (rst) err_cnt <= '0;
      else if (out_valid && err_out && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_therm_encoder.sv
// tb_therm_encoder: directed self-checking bench for therm_encoder.
module tb_therm_encoder;
   localparam int N = 255;
   logic           clk = 1'b0;
   logic           rst, in_valid;
   logic [N-1:0]   therm_in, pat;
   logic           out_valid, err_out;
   logic [7:0]     code_out;
   int             total = 0, bad = 0;
`ifdef THERM_ENC_ERR_CNT_EN
   logic [15:0]    err_cnt;
`endif

   therm_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .therm_in(therm_in),
      .out_valid(out_valid), .code_out(code_out), .err_out(err_out)
`ifdef THERM_ENC_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] ones(input int k);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < k; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic step(input logic v, input logic [N-1:0] d);
      in_valid = v;
      therm_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out3(input string tag, input logic v, input logic [7:0] c, input logic e);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".code"}, {24'd0, code_out}, {24'd0, c});
      chk({tag, ".err"}, {31'd0, err_out}, {31'd0, e});
   endtask

   initial begin
      rst = 1'b1;
      step(1'b0, '0);
      step(1'b0, '0);
      out3("reset", 1'b0, 8'd0, 1'b0);
`ifdef THERM_ENC_ERR_CNT_EN
      chk("reset.cnt", {16'd0, err_cnt}, 32'd0);
`endif
      rst = 1'b0;

      // sweep: k ones on consecutive clocks, result of sample k-2 visible after step k
      for (int k = 0; k < 258; k++) begin
         step(k < 256, k < 256 ? ones(k) : '0);
         if (k >= 2) out3("sweep", 1'b1, 8'(k - 2), 1'b0);
      end
      step(1'b0, '0);
      chk("sweep.tail", {31'd0, out_valid}, 32'd0);

      // bubble hold
      pat = ones(120);
      pat[130] = 1'b1;
      step(1'b1, ones(100));
      step(1'b1, pat);
      step(1'b1, ones(50));
      out3("bub.first", 1'b1, 8'd100, 1'b0);
      step(1'b0, '0);
      out3("bub.hold", 1'b1, 8'd100, 1'b1);
      step(1'b0, '0);
      out3("bub.clean", 1'b1, 8'd50, 1'b0);

      // valid gaps, junk on therm_in while idle
      step(1'b1, ones(10));
      step(1'b0, ones(77));
      step(1'b0, ones(77));
      out3("gap.a", 1'b1, 8'd10, 1'b0);
      step(1'b1, ones(20));
      out3("gap.b", 1'b0, 8'd10, 1'b0);
      step(1'b0, ones(77));
      out3("gap.c", 1'b0, 8'd10, 1'b0);
      step(1'b0, '0);
      out3("gap.d", 1'b1, 8'd20, 1'b0);

      // reset mid-stream, sample during rst dropped, first post-reset error gives 0
      step(1'b1, ones(30));
      step(1'b1, ones(40));
      step(1'b1, ones(50));
      out3("mid.pre", 1'b1, 8'd30, 1'b0);
      rst = 1'b1;
      step(1'b1, ones(60));
      rst = 1'b0;
      out3("mid.rst", 1'b0, 8'd0, 1'b0);
      pat = '0;
      pat[5] = 1'b1;
      step(1'b1, pat);
      chk("mid.gone0", {31'd0, out_valid}, 32'd0);
      step(1'b0, '0);
      chk("mid.gone1", {31'd0, out_valid}, 32'd0);
      step(1'b0, '0);
      out3("mid.err0", 1'b1, 8'd0, 1'b1);

      // edges
      pat = '0;
      pat[254] = 1'b1;
      step(1'b1, '0);
      step(1'b1, ones(1));
      step(1'b1, ones(255));
      out3("edge.zero", 1'b1, 8'd0, 1'b0);
      step(1'b1, pat);
      out3("edge.bit0", 1'b1, 8'd1, 1'b0);
      step(1'b0, '0);
      out3("edge.ones", 1'b1, 8'd255, 1'b0);
      step(1'b0, '0);
      out3("edge.top", 1'b1, 8'd255, 1'b1);

`ifdef THERM_ENC_ERR_CNT_EN
      rst = 1'b1;
      step(1'b0, '0);
      rst = 1'b0;
      chk("cnt.clr", {16'd0, err_cnt}, 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, pat);
      for (int i = 0; i < 4; i++) step(1'b0, '0);
      chk("cnt.three", {16'd0, err_cnt}, 32'd3);
      rst = 1'b1;
      step(1'b0, '0);
      rst = 1'b0;
      chk("cnt.rst", {16'd0, err_cnt}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
